cache_access_ctrl: RTL and testbench

Request sequencer for the two-level, 2-way set-associative tag store (L1: 512 sets, L2: 1024 sets).
- Accepts CPU lookups over a valid/ready handshake and performs the L1 probe, then the L2 probe.
- On a full miss, issues a memory fetch and refills L2 and L1.
- Owns the tag/valid arrays, the per-set replacement pointers and a sequenced whole-cache flush.

---
 rtl/cache_pkg.sv | 35 +++
 rtl/cache_tag_bank.sv | 68 ++++++
 rtl/cache_access_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_cache_access_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the two-level tag-store request sequencer.
// Holds address field widths, response codes, the FSM state encoding and
// packed views of the request address for the L1 and L2 index/tag split.
package cache_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned TAG1_W = 3;
    localparam int unsigned SET1_W = 9;
    localparam int unsigned TAG2_W = 2;
    localparam int unsigned SET2_W = 10;

    localparam logic [1:0] RESP_L1HIT = 2'b01;
    localparam logic [1:0] RESP_L2HIT = 2'b11;
    localparam logic [1:0] RESP_MISS  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOOK1 = 3'd1,
        ST_LOOK2 = 3'd2,
        ST_MEM   = 3'd3,
        ST_RESP  = 3'd4,
        ST_FLUSH = 3'd5
    } state_t;

    typedef struct packed {
        logic [TAG1_W-1:0] tag;
        logic [SET1_W-1:0] set;
    } l1_addr_t;

    typedef struct packed {
        logic [TAG2_W-1:0] tag;
        logic [SET2_W-1:0] set;
    } l2_addr_t;

endpackage

// File: rtl/cache_tag_bank.sv
// Two-way tag/valid store with a 1-bit replacement pointer per set.
// Ports:
//   clk, rst            clock, async active-high reset (valids and pointers)
//   look_set/look_tag   combinational probe, result on hit_c
//   fill_en/set/tag     write tag into the way selected by the set pointer,
//                       mark it valid and toggle the pointer
//   clr_en/clr_set      invalidate both ways and zero the pointer of a set
module cache_tag_bank #(
    parameter int unsigned TAG_W = 3,
    parameter int unsigned SET_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SET_W-1:0] look_set,
    input  logic [TAG_W-1:0] look_tag,
    output logic             hit_c,
    input  logic             fill_en,
    input  logic [SET_W-1:0] fill_set,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic             clr_en,
    input  logic [SET_W-1:0] clr_set
);

    localparam int unsigned SETS = 1 << SET_W;

    logic [TAG_W-1:0] tag0 [SETS];
    logic [TAG_W-1:0] tag1 [SETS];
    logic [SETS-1:0]  vld0;
    logic [SETS-1:0]  vld1;
    logic [SETS-1:0]  ptr;

    // Valid bits and pointers; clear wins if both ports are ever active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld0 <= '0;
            vld1 <= '0;
            ptr  <= '0;
        end else if (clr_en) begin
            vld0[clr_set] <= 1'b0;
            vld1[clr_set] <= 1'b0;
            ptr[clr_set]  <= 1'b0;
        end else if (fill_en) begin
            if (ptr[fill_set]) begin
                vld1[fill_set] <= 1'b1;
            end else begin
                vld0[fill_set] <= 1'b1;
            end
            ptr[fill_set] <= ~ptr[fill_set];
        end
    end

    // Tag storage carries no reset; valid bits qualify every use.
    always_ff @(posedge clk) begin
        if (fill_en && !clr_en) begin
            if (ptr[fill_set]) begin
                tag1[fill_set] <= fill_tag;
            end else begin
                tag0[fill_set] <= fill_tag;
            end
        end
    end

    always_comb begin
        hit_c = (vld0[look_set] && (tag0[look_set] == look_tag)) ||
                (vld1[look_set] && (tag1[look_set] == look_tag));
    end

endmodule

// File: rtl/cache_access_ctrl.sv
// Request sequencer for the two-level, 2-way set-associative tag store.
// Probes L1 then L2, fetches from memory on a full miss and refills both
// levels, and runs a one-set-per-cycle whole-cache flush.
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid/ready/addr     lookup request handshake
//   resp_valid/ready/code    result handshake (01 L1 hit, 11 L2 hit, 10 miss)
//   mem_req/addr, mem_ack    memory fetch request (level) and completion pulse
//   flush_req                flush request pulse
//   flush_busy, flush_done   flush in progress / last flush cycle
module cache_access_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [1:0]        resp_code,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              flush_req,
    output logic              flush_busy,
    output logic              flush_done
);

    localparam logic [SET2_W-1:0] FLUSH_LAST = '1;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   addr_q;
    logic                started;
    logic                flush_pending;
    logic [SET2_W-1:0]   flush_idx;
    logic [SET2_W-1:0]   flush_idx_d;

    logic                l1_hit_c;
    logic                l2_hit_c;
    logic                accept_c;
    logic                ack_c;
    logic                resp_take_c;
    logic                flush_end_c;

    logic                resp_valid_d;
    logic [1:0]          resp_code_d;
    logic                mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic                flush_busy_d;
    logic                flush_done_d;

    logic                l1_fill_en;
    logic                l2_fill_en;
    logic                l1_clr_en;
    logic                l2_clr_en;

    l1_addr_t            l1a;
    l2_addr_t            l2a;

    assign l1a = l1_addr_t'(addr_q);
    assign l2a = l2_addr_t'(addr_q);

    // Ready is gated by 'started' so it stays low until the first clock after reset.
    assign req_ready   = (state == ST_IDLE) && started && !flush_pending && !flush_req;
    assign accept_c    = req_ready && req_valid;
    // An ack only counts once the fetch request is actually visible.
    assign ack_c       = (state == ST_MEM) && mem_req && mem_ack;
    assign resp_take_c = (state == ST_RESP) && resp_valid && resp_ready;
    assign flush_end_c = (state == ST_FLUSH) && (flush_idx == FLUSH_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (flush_req || flush_pending) begin
                    next_state = ST_FLUSH;
                end else if (accept_c) begin
                    next_state = ST_LOOK1;
                end
            end
            ST_LOOK1: next_state = l1_hit_c ? ST_RESP : ST_LOOK2;
            ST_LOOK2: next_state = l2_hit_c ? ST_RESP : ST_MEM;
            ST_MEM: begin
                if (ack_c) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_take_c) begin
                    next_state = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flush_end_c) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output and array-control logic (outputs are registered below).
    always_comb begin
        resp_valid_d = (state == ST_RESP) && !resp_take_c;
        resp_code_d  = resp_code;
        mem_req_d    = (state == ST_MEM) && !ack_c;
        mem_addr_d   = mem_addr;
        flush_idx_d  = (state == ST_FLUSH) ? flush_idx + SET2_W'(1) : '0;
        // Busy/done are derived from the upcoming state so they line up with FLUSH exactly.
        flush_busy_d = (next_state == ST_FLUSH);
        flush_done_d = (next_state == ST_FLUSH) && (flush_idx_d == FLUSH_LAST);
        l1_fill_en   = 1'b0;
        l2_fill_en   = 1'b0;
        l1_clr_en    = 1'b0;
        l2_clr_en    = 1'b0;

        if (state == ST_LOOK1 && l1_hit_c) begin
            resp_code_d = RESP_L1HIT;
        end
        if (state == ST_LOOK2 && l2_hit_c) begin
            resp_code_d = RESP_L2HIT;
            l1_fill_en  = 1'b1;
        end
        if (state == ST_MEM) begin
            mem_addr_d = addr_q;
        end
        if (ack_c) begin
            resp_code_d = RESP_MISS;
            l1_fill_en  = 1'b1;
            l2_fill_en  = 1'b1;
        end
        if (state == ST_FLUSH) begin
            l2_clr_en = 1'b1;
            // L1 has half as many sets; only the lower half of the sweep touches it.
            l1_clr_en = (flush_idx[SET2_W-1:SET1_W] == '0);
        end
    end

    // Registered outputs and datapath state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid    <= 1'b0;
            resp_code     <= 2'b00;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            flush_busy    <= 1'b0;
            flush_done    <= 1'b0;
            flush_idx     <= '0;
            addr_q        <= '0;
            started       <= 1'b0;
            flush_pending <= 1'b0;
        end else begin
            resp_valid <= resp_valid_d;
            resp_code  <= resp_code_d;
            mem_req    <= mem_req_d;
            mem_addr   <= mem_addr_d;
            flush_busy <= flush_busy_d;
            flush_done <= flush_done_d;
            flush_idx  <= flush_idx_d;
            started    <= 1'b1;
            if (accept_c) begin
                addr_q <= req_addr;
            end
            // A request arriving during a flush is already satisfied by it.
            if (flush_end_c) begin
                flush_pending <= 1'b0;
            end else if (flush_req && state != ST_IDLE && state != ST_FLUSH) begin
                flush_pending <= 1'b1;
            end
        end
    end

    cache_tag_bank #(
        .TAG_W (TAG1_W),
        .SET_W (SET1_W)
    ) u_l1 (
        .clk      (clk),
        .rst      (rst),
        .look_set (l1a.set),
        .look_tag (l1a.tag),
        .hit_c    (l1_hit_c),
        .fill_en  (l1_fill_en),
        .fill_set (l1a.set),
        .fill_tag (l1a.tag),
        .clr_en   (l1_clr_en),
        .clr_set  (flush_idx[SET1_W-1:0])
    );

    cache_tag_bank #(
        .TAG_W (TAG2_W),
        .SET_W (SET2_W)
    ) u_l2 (
        .clk      (clk),
        .rst      (rst),
        .look_set (l2a.set),
        .look_tag (l2a.tag),
        .hit_c    (l2_hit_c),
        .fill_en  (l2_fill_en),
        .fill_set (l2a.set),
        .fill_tag (l2a.tag),
        .clr_en   (l2_clr_en),
        .clr_set  (flush_idx)
    );

endmodule

// File: tb/tb_cache_access_ctrl.sv
// Directed plus randomized bench for cache_access_ctrl with a behavioural
// two-level cache model (per-set way arrays with round-robin pointer).
module tb_cache_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_code;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_ack;
    logic        flush_req;
    logic        flush_busy;
    logic        flush_done;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state.
    bit [2:0] m1_tag [512][2];
    bit       m1_v   [512][2];
    bit       m1_p   [512];
    bit [1:0] m2_tag [1024][2];
    bit       m2_v   [1024][2];
    bit       m2_p   [1024];

    cache_access_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_code  (resp_code),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .flush_done (flush_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void m_reset();
        for (int s = 0; s < 512; s++) begin
            m1_v[s][0] = 1'b0; m1_v[s][1] = 1'b0; m1_p[s] = 1'b0;
        end
        for (int s = 0; s < 1024; s++) begin
            m2_v[s][0] = 1'b0; m2_v[s][1] = 1'b0; m2_p[s] = 1'b0;
        end
    endfunction

    // Returns the expected response code and applies the fills the access causes.
    function automatic logic [1:0] m_access(input logic [11:0] a);
        int       s1 = int'(a[8:0]);
        int       s2 = int'(a[9:0]);
        bit [2:0] t1 = a[11:9];
        bit [1:0] t2 = a[11:10];
        int       w;
        for (int k = 0; k < 2; k++) begin
            if (m1_v[s1][k] && m1_tag[s1][k] == t1) return 2'b01;
        end
        for (int k = 0; k < 2; k++) begin
            if (m2_v[s2][k] && m2_tag[s2][k] == t2) begin
                w = int'(m1_p[s1]);
                m1_tag[s1][w] = t1; m1_v[s1][w] = 1'b1; m1_p[s1] = ~m1_p[s1];
                return 2'b11;
            end
        end
        w = int'(m2_p[s2]);
        m2_tag[s2][w] = t2; m2_v[s2][w] = 1'b1; m2_p[s2] = ~m2_p[s2];
        w = int'(m1_p[s1]);
        m1_tag[s1][w] = t1; m1_v[s1][w] = 1'b1; m1_p[s1] = ~m1_p[s1];
        return 2'b10;
    endfunction

    // One complete transaction: accept, latency/fetch checks, optional backpressure.
    task automatic do_req(input logic [11:0] a, input int ack_wait, input int hold,
                          input bit flush_in_mem);
        logic [1:0] exp;
        int t;
        int cyc;
        exp = m_access(a);
        t = 0;
        while (req_ready !== 1'b1 && t < 3000) begin
            tick();
            t++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
        req_addr  = 12'($urandom);
        cyc = 0;
        while (cyc < 200 && resp_valid !== 1'b1 && mem_req !== 1'b1) begin
            tick();
            cyc++;
        end
        if (mem_req === 1'b1) begin
            check("fetch_code", 32'(exp), 32'(2'b10));
            check("fetch_latency", 32'(cyc), 32'd3);
            check("mem_addr", 32'(mem_addr), 32'(a));
            if (flush_in_mem) begin
                flush_req = 1'b1;
                tick();
                flush_req = 1'b0;
            end
            repeat (ack_wait) tick();
            check("mem_req_held", {19'd0, mem_req, mem_addr}, {19'd0, 1'b1, a});
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            check("mem_req_drop", 32'(mem_req), 32'd0);
            tick();
        end else begin
            check("hit_latency", 32'(cyc), (exp == 2'b01) ? 32'd2 : 32'd3);
        end
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_code", 32'(resp_code), 32'(exp));
        repeat (hold) begin
            tick();
            check("backpressure", {28'd0, resp_valid, resp_code, req_ready},
                  {28'd0, 1'b1, exp, 1'b0});
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("resp_drop", 32'(resp_valid), 32'd0);
        check("ready_after_resp", 32'(req_ready), flush_in_mem ? 32'd0 : 32'd1);
    endtask

    // Measures a flush already started or about to start from IDLE.
    task automatic wait_flush();
        int busy = 0;
        int done = 0;
        int done_at = -1;
        int t = 0;
        bit ready_seen = 1'b0;
        while (t < 3000 && !(busy > 0 && flush_busy !== 1'b1)) begin
            if (flush_busy === 1'b1) begin
                busy++;
                if (req_ready === 1'b1) ready_seen = 1'b1;
            end
            if (flush_done === 1'b1) begin
                done++;
                done_at = busy;
            end
            tick();
            t++;
        end
        check("flush_busy_cycles", 32'(busy), 32'd1024);
        check("flush_done_count", 32'(done), 32'd1);
        check("flush_done_last", 32'(done_at), 32'd1024);
        check("flush_no_ready", 32'(ready_seen), 32'd0);
        check("ready_after_flush", 32'(req_ready), 32'd1);
        m_reset();
    endtask

    initial begin
        logic [11:0] a;
        logic [2:0]  hi;
        int t;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b0;
        mem_ack    = 1'b0;
        flush_req  = 1'b0;
        m_reset();
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp", {29'd0, resp_valid, resp_code}, 32'd0);
        check("rst_mem", {19'd0, mem_req, mem_addr}, 32'd0);
        check("rst_flush", {30'd0, flush_busy, flush_done}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("ready_before_first_clk", 32'(req_ready), 32'd0);
        tick();
        check("ready_after_first_clk", 32'(req_ready), 32'd1);

        // Cold miss, then L1 hit.
        do_req(12'hA05, 3, 0, 1'b0);
        do_req(12'hA05, 0, 0, 1'b0);
        // L1 set 5 conflicts; A05 survives in L2.
        do_req(12'h205, 1, 0, 1'b0);
        do_req(12'h405, 0, 0, 1'b0);
        do_req(12'hA05, 0, 0, 1'b0);
        do_req(12'hA05, 0, 0, 1'b0);
        // Backpressure.
        do_req(12'hA05, 0, 10, 1'b0);

        // Stray ack/ready in IDLE must do nothing.
        mem_ack    = 1'b1;
        resp_ready = 1'b1;
        tick();
        mem_ack    = 1'b0;
        resp_ready = 1'b0;
        tick();
        check("idle_ignore", {29'd0, resp_valid, mem_req, req_ready}, 32'd1);

        // Flush requested during a fetch runs after the response.
        do_req(12'h3F7, 2, 0, 1'b1);
        wait_flush();
        do_req(12'hA05, 0, 0, 1'b0);

        // Flush wins over a simultaneous request.
        do_req(12'h123, 0, 0, 1'b0);
        flush_req = 1'b1;
        req_valid = 1'b1;
        req_addr  = 12'h123;
        #1;
        check("flush_priority_ready", 32'(req_ready), 32'd0);
        tick();
        flush_req = 1'b0;
        req_valid = 1'b0;
        wait_flush();
        do_req(12'h123, 0, 0, 1'b0);

        // Reset while a fetch is outstanding.
        void'(m_access(12'h7C1));
        req_valid = 1'b1;
        req_addr  = 12'h7C1;
        tick();
        req_valid = 1'b0;
        t = 0;
        while (mem_req !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        check("mid_reset_mem_seen", 32'(mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_reset_outputs", {29'd0, mem_req, resp_valid, req_ready}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        m_reset();
        do_req(12'hA05, 0, 0, 1'b0);

        // Randomized traffic over a small address pool.
        for (int i = 0; i < 60; i++) begin
            hi = 3'($urandom_range(0, 7));
            a  = {hi, 9'd5 + 9'($urandom_range(0, 1))};
            do_req(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
